id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 SHALL have port clk_i  input  1  single clock, all state on posedge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports RSdata_i / RTdata_i  input  DATA_W  operands from register file read ports.
REQ-006 SHALL have ports RSaddr_i / RTaddr_i / RDaddr_i  input  5  ID-stage register addresses.
REQ-007 SHALL have port imm_i  input  DATA_W  sign-extended immediate.
REQ-008 SHALL have ports RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, ALUSrc_i, RegDst_i  input  1 each  ID control bits.
REQ-009 SHALL have port ALUOp_i  input  2  ALU operation class.
REQ-010 SHALL have port valid_i  input  1  ID slot holds a real instruction.
REQ-011 SHALL have port flush_i  input  1  branch/jump taken, squash ID instruction.
REQ-012 SHALL have port hold_i  input  1  downstream freeze (memory wait).
REQ-013 SHALL have registered outputs RSdata_o, RTdata_o, imm_o (DATA_W), RSaddr_o, RTaddr_o, RDaddr_o (5), all control bits with _o suffix, valid_o (1).
REQ-014 SHALL have port stall_o  output  1  combinational load-use stall to PC and IF/ID.
REQ-015 SHALL have port stall_cnt_o  output  CNT_W  saturating count of stall cycles.

Function
REQ-016 Load-use hazard = valid_o & MemRead_o & (RTaddr_o != 0) & valid_i & (RTaddr_o == RSaddr_i | RTaddr_o == RTaddr_i).
REQ-017 stall_o SHALL equal hazard & ~flush_i, same cycle, no register.
REQ-018 Posedge update priority SHALL be: hold_i > flush_i > stall_o > normal load.
REQ-019 hold_i=1: all registered outputs and stall_cnt_o retain value.
REQ-020 flush_i=1 (no hold): register loads bubble -- valid_o=0, all control outputs 0, data/address outputs 0.
REQ-021 stall_o=1 (no hold, no flush): register loads bubble identical to REQ-020.
REQ-022 Normal load: every _o takes its _i value; valid_o=valid_i; if valid_i=0 control outputs SHALL be forced 0.
REQ-023 Latency SHALL be exactly one cycle from ID input to EX output.
REQ-024 A single load followed by dependent instruction SHALL produce exactly one stall cycle; bubble in EX clears the hazard next cycle.
REQ-025 stall_cnt_o SHALL increment by 1 on each posedge where stall_o=1 and hold_i=0; saturate at all-ones, never wrap.
REQ-026 Register $0 as load destination SHALL never raise stall_o.

Reset
REQ-027 rst_i low SHALL immediately clear all registered outputs to 0, valid_o=0, stall_cnt_o=0, regardless of clock.
REQ-028 stall_o SHALL be 0 while rst_i low (valid_o=0).
REQ-029 Reset release mid-stream: first posedge after release performs normal REQ-018 evaluation.

Structure
REQ-030 Shared package SHALL hold ALUOp encodings, control-bundle width, and the all-zero bubble constant.
REQ-031 Hazard compare (REQ-016) SHALL be one combinational sub-module hazard_detect; pipeline register and counter in id_ex_stage.

Verification
REQ-032 Reset: rst_i=0 mid-cycle -> all outputs 0 at once, stall_cnt_o=0.
REQ-033 lw $2 (RTaddr=2, MemRead=1) then add rs=2 -> stall_o=1 one cycle, EX gets bubble, add reaches EX next cycle, stall_cnt_o=1.
REQ-034 lw $0 then add rs=0 -> stall_o=0, no bubble.
REQ-035 Hazard and flush_i=1 same cycle -> stall_o=0, bubble loaded, stall_cnt_o unchanged.
REQ-036 hold_i=1 for 3 cycles with hazard present -> outputs frozen, stall_cnt_o unchanged; release -> stall proceeds.
REQ-037 CNT_W=4, 20 stall cycles -> stall_cnt_o saturates at 0xF.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared definitions for the ID/EX pipeline stage.
//   - ALUOp encodings driven by the decoder
//   - control bundle carried from ID to EX, and its width
//   - the all-zero bubble used when EX must receive a no-op
package id_ex_stage_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;  // loads/stores: address add
  localparam logic [1:0] ALUOP_SUB   = 2'b01;  // branch compare
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;  // decode from funct field
  localparam logic [1:0] ALUOP_IMM   = 2'b11;  // immediate arithmetic/logic

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam int    CTRL_W      = $bits(ctrl_t);
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: purely combinational load-use hazard compare.
// Ports:
//   ex_valid_i, ex_mem_read_i, ex_rt_addr_i : instruction currently in EX
//   id_valid_i, id_rs_addr_i, id_rt_addr_i  : instruction currently in ID
//   hazard_o                                : ID reads the register EX is loading
module hazard_detect (
  input  logic       ex_valid_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rt_addr_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs_addr_i,
  input  logic [4:0] id_rt_addr_i,
  output logic       hazard_o
);

  logic addr_match;
  logic ex_is_load;

  // $0 is hard-wired to zero, so a load targeting it never creates a dependence.
  assign ex_is_load = ex_valid_i & ex_mem_read_i & (ex_rt_addr_i != 5'd0);
  assign addr_match = (ex_rt_addr_i == id_rs_addr_i) | (ex_rt_addr_i == id_rt_addr_i);
  assign hazard_o   = ex_is_load & id_valid_i & addr_match;

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall detection and a
// saturating stall-cycle counter.
// Ports:
//   clk_i, rst_i (async, active-low)
//   RSdata_i/RTdata_i/imm_i, RSaddr_i/RTaddr_i/RDaddr_i, control bits, valid_i : ID slot
//   flush_i : squash the ID instruction (taken branch/jump)
//   hold_i  : freeze the whole stage (downstream memory wait)
//   *_o     : registered EX-side copies, one cycle after ID
//   stall_o : combinational load-use stall to PC and IF/ID
//   stall_cnt_o : saturating count of cycles in which a stall was taken
// valid semantics: valid_o=1 means the EX slot holds a real instruction; a
// bubble has valid_o=0 with every control bit, datum and address zero.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] RSdata_i,
  input  logic [DATA_W-1:0] RTdata_i,
  input  logic [4:0]        RSaddr_i,
  input  logic [4:0]        RTaddr_i,
  input  logic [4:0]        RDaddr_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic              RegWrite_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              MemtoReg_i,
  input  logic              ALUSrc_i,
  input  logic              RegDst_i,
  input  logic [1:0]        ALUOp_i,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic [DATA_W-1:0] RSdata_o,
  output logic [DATA_W-1:0] RTdata_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [4:0]        RSaddr_o,
  output logic [4:0]        RTaddr_o,
  output logic [4:0]        RDaddr_o,
  output logic              RegWrite_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              MemtoReg_o,
  output logic              ALUSrc_o,
  output logic              RegDst_o,
  output logic [1:0]        ALUOp_o,
  output logic              valid_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic [4:0]        rs_addr_q, rs_addr_d;
  logic [4:0]        rt_addr_q, rt_addr_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  ctrl_t ctrl_in;
  logic  hazard;

  assign ctrl_in = '{reg_write:  RegWrite_i, mem_read: MemRead_i, mem_write: MemWrite_i,
                     mem_to_reg: MemtoReg_i, alu_src:  ALUSrc_i,  reg_dst:   RegDst_i,
                     alu_op:     ALUOp_i};

  hazard_detect u_hazard_detect (
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_rt_addr_i  (rt_addr_q),
    .id_valid_i    (valid_i),
    .id_rs_addr_i  (RSaddr_i),
    .id_rt_addr_i  (RTaddr_i),
    .hazard_o      (hazard)
  );

  // A flush already discards the dependent instruction, so no stall is needed.
  assign stall_o = hazard & ~flush_i;

  always_comb begin
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_d       = imm_q;
    rs_addr_d   = rs_addr_q;
    rt_addr_d   = rt_addr_q;
    rd_addr_d   = rd_addr_q;
    ctrl_d      = ctrl_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;

    if (hold_i) begin
      // freeze everything, counter included
    end else if (flush_i || stall_o) begin
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      rs_addr_d = '0;
      rt_addr_d = '0;
      rd_addr_d = '0;
      ctrl_d    = CTRL_BUBBLE;
      valid_d   = 1'b0;
      if (stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end else begin
      rs_data_d = RSdata_i;
      rt_data_d = RTdata_i;
      imm_d     = imm_i;
      rs_addr_d = RSaddr_i;
      rt_addr_d = RTaddr_i;
      rd_addr_d = RDaddr_i;
      ctrl_d    = valid_i ? ctrl_in : CTRL_BUBBLE;
      valid_d   = valid_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rd_addr_q   <= '0;
      ctrl_q      <= CTRL_BUBBLE;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      rs_addr_q   <= rs_addr_d;
      rt_addr_q   <= rt_addr_d;
      rd_addr_q   <= rd_addr_d;
      ctrl_q      <= ctrl_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign RSdata_o    = rs_data_q;
  assign RTdata_o    = rt_data_q;
  assign imm_o       = imm_q;
  assign RSaddr_o    = rs_addr_q;
  assign RTaddr_o    = rt_addr_q;
  assign RDaddr_o    = rd_addr_q;
  assign RegWrite_o  = ctrl_q.reg_write;
  assign MemRead_o   = ctrl_q.mem_read;
  assign MemWrite_o  = ctrl_q.mem_write;
  assign MemtoReg_o  = ctrl_q.mem_to_reg;
  assign ALUSrc_o    = ctrl_q.alu_src;
  assign RegDst_o    = ctrl_q.reg_dst;
  assign ALUOp_o     = ctrl_q.alu_op;
  assign valid_o     = valid_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed-vector bench for id_ex_stage. Two instances share
// the same stimulus: dut (CNT_W=16) for exact counts, dut4 (CNT_W=4) for
// counter saturation.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam int DATA_W = 32;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [DATA_W-1:0] RSdata_i, RTdata_i, imm_i;
  logic [4:0]        RSaddr_i, RTaddr_i, RDaddr_i;
  logic RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, ALUSrc_i, RegDst_i;
  logic [1:0]        ALUOp_i;
  logic valid_i, flush_i, hold_i;

  logic [DATA_W-1:0] RSdata_o, RTdata_o, imm_o;
  logic [4:0]        RSaddr_o, RTaddr_o, RDaddr_o;
  logic RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, ALUSrc_o, RegDst_o;
  logic [1:0]        ALUOp_o;
  logic valid_o, stall_o;
  logic [15:0]       stall_cnt_o;

  logic [DATA_W-1:0] RSdata4, RTdata4, imm4;
  logic [4:0]        RSaddr4, RTaddr4, RDaddr4;
  logic RegWrite4, MemRead4, MemWrite4, MemtoReg4, ALUSrc4, RegDst4;
  logic [1:0]        ALUOp4;
  logic valid4, stall4;
  logic [3:0]        stall_cnt4;

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .RSdata_i(RSdata_i), .RTdata_i(RTdata_i),
    .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i), .imm_i(imm_i),
    .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .MemtoReg_i(MemtoReg_i), .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i), .ALUOp_i(ALUOp_i),
    .valid_i(valid_i), .flush_i(flush_i), .hold_i(hold_i),
    .RSdata_o(RSdata_o), .RTdata_o(RTdata_o), .imm_o(imm_o),
    .RSaddr_o(RSaddr_o), .RTaddr_o(RTaddr_o), .RDaddr_o(RDaddr_o),
    .RegWrite_o(RegWrite_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
    .MemtoReg_o(MemtoReg_o), .ALUSrc_o(ALUSrc_o), .RegDst_o(RegDst_o), .ALUOp_o(ALUOp_o),
    .valid_o(valid_o), .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
  );

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(4)) dut4 (
    .clk_i(clk_i), .rst_i(rst_i),
    .RSdata_i(RSdata_i), .RTdata_i(RTdata_i),
    .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .RDaddr_i(RDaddr_i), .imm_i(imm_i),
    .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .MemtoReg_i(MemtoReg_i), .ALUSrc_i(ALUSrc_i), .RegDst_i(RegDst_i), .ALUOp_i(ALUOp_i),
    .valid_i(valid_i), .flush_i(flush_i), .hold_i(hold_i),
    .RSdata_o(RSdata4), .RTdata_o(RTdata4), .imm_o(imm4),
    .RSaddr_o(RSaddr4), .RTaddr_o(RTaddr4), .RDaddr_o(RDaddr4),
    .RegWrite_o(RegWrite4), .MemRead_o(MemRead4), .MemWrite_o(MemWrite4),
    .MemtoReg_o(MemtoReg4), .ALUSrc_o(ALUSrc4), .RegDst_o(RegDst4), .ALUOp_o(ALUOp4),
    .valid_o(valid4), .stall_o(stall4), .stall_cnt_o(stall_cnt4)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_bad    = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] im,
                        input ctrl_t c, input logic v);
    RSaddr_i = rs; RTaddr_i = rt; RDaddr_i = rd;
    RSdata_i = rsd; RTdata_i = rtd; imm_i = im;
    RegWrite_i = c.reg_write; MemRead_i = c.mem_read; MemWrite_i = c.mem_write;
    MemtoReg_i = c.mem_to_reg; ALUSrc_i = c.alu_src; RegDst_i = c.reg_dst;
    ALUOp_i = c.alu_op; valid_i = v;
  endtask

  // advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // bubble-state check of the 16-bit instance
  task automatic check_bubble(input string tag);
    check_eq({tag, "_valid"}, valid_o, 1'b0);
    check_eq({tag, "_ctrl"}, {RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o,
                              ALUSrc_o, RegDst_o, ALUOp_o}, 8'h00);
    check_eq({tag, "_data"}, {RSdata_o, RTdata_o}, 64'h0);
    check_eq({tag, "_imm_addr"}, {imm_o, RSaddr_o, RTaddr_o, RDaddr_o}, 47'h0);
  endtask

  ctrl_t c_lw, c_add, c_none;

  initial begin
    c_lw   = '{reg_write:1'b1, mem_read:1'b1, mem_write:1'b0, mem_to_reg:1'b1,
               alu_src:1'b1, reg_dst:1'b0, alu_op:ALUOP_ADD};
    c_add  = '{reg_write:1'b1, mem_read:1'b0, mem_write:1'b0, mem_to_reg:1'b0,
               alu_src:1'b0, reg_dst:1'b1, alu_op:ALUOP_RTYPE};
    c_none = CTRL_BUBBLE;
    flush_i = 1'b0;
    hold_i  = 1'b0;
    set_id(5'd9, 5'd9, 5'd9, 32'hAAAA_5555, 32'h1234_5678, 32'hFFFF_FFF0, c_lw, 1'b1);

    // reset state with active-looking inputs
    #3;
    check_bubble("reset");
    check_eq("reset_stall", stall_o, 1'b0);
    check_eq("reset_cnt", stall_cnt_o, 16'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // normal load, one-cycle latency
    set_id(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, c_add, 1'b1);
    #1;
    check_eq("norm_stall", stall_o, 1'b0);
    step();
    check_eq("norm_data", {RSdata_o, RTdata_o}, {32'h11, 32'h22});
    check_eq("norm_imm", imm_o, 32'h33);
    check_eq("norm_addr", {RSaddr_o, RTaddr_o, RDaddr_o}, {5'd1, 5'd2, 5'd3});
    check_eq("norm_ctrl", {RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o,
                           ALUSrc_o, RegDst_o, ALUOp_o}, 8'b1000_0110);
    check_eq("norm_valid", valid_o, 1'b1);

    // invalid slot: data loads, control forced to zero
    set_id(5'd4, 5'd5, 5'd6, 32'h44, 32'h55, 32'h66, c_lw, 1'b0);
    step();
    check_eq("inv_valid", valid_o, 1'b0);
    check_eq("inv_ctrl", {RegWrite_o, MemRead_o, MemtoReg_o, ALUSrc_o, ALUOp_o}, 6'h0);
    check_eq("inv_data", {RSdata_o, RDaddr_o}, {32'h44, 5'd6});

    // load-use: lw $2 then add rs=2
    set_id(5'd1, 5'd2, 5'd0, 32'h100, 32'h0, 32'h8, c_lw, 1'b1);
    #1;
    check_eq("lw_stall", stall_o, 1'b0);
    step();
    check_eq("lw_ex", {MemRead_o, RTaddr_o}, {1'b1, 5'd2});
    set_id(5'd2, 5'd4, 5'd5, 32'h200, 32'h300, 32'h0, c_add, 1'b1);
    #1;
    check_eq("lu_stall", stall_o, 1'b1);
    step();
    check_bubble("lu_bubble");
    check_eq("lu_cnt", stall_cnt_o, 16'd1);
    check_eq("lu_cnt4", stall_cnt4, 4'd1);
    check_eq("lu_stall_clr", stall_o, 1'b0);
    step();
    check_eq("lu_add_ex", {valid_o, RSaddr_o, RDaddr_o, RegDst_o}, {1'b1, 5'd2, 5'd5, 1'b1});
    check_eq("lu_cnt_hold", stall_cnt_o, 16'd1);

    // lw $0 then add rs=0: no stall
    set_id(5'd1, 5'd0, 5'd0, 32'h1, 32'h0, 32'h4, c_lw, 1'b1);
    step();
    set_id(5'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, c_add, 1'b1);
    #1;
    check_eq("r0_stall", stall_o, 1'b0);
    step();
    check_eq("r0_ex", {valid_o, RDaddr_o, RegWrite_o}, {1'b1, 5'd7, 1'b1});
    check_eq("r0_cnt", stall_cnt_o, 16'd1);

    // hazard together with flush
    set_id(5'd1, 5'd6, 5'd0, 32'h1, 32'h0, 32'h4, c_lw, 1'b1);
    step();
    set_id(5'd6, 5'd3, 5'd8, 32'h9, 32'h9, 32'h9, c_add, 1'b1);
    flush_i = 1'b1;
    #1;
    check_eq("fl_stall", stall_o, 1'b0);
    step();
    flush_i = 1'b0;
    check_bubble("fl_bubble");
    check_eq("fl_cnt", stall_cnt_o, 16'd1);

    // hold for 3 cycles with hazard present
    set_id(5'd1, 5'd7, 5'd0, 32'h71, 32'h72, 32'h73, c_lw, 1'b1);
    step();
    set_id(5'd1, 5'd7, 5'd9, 32'hA, 32'hB, 32'hC, c_add, 1'b1);
    hold_i = 1'b1;
    #1;
    check_eq("hold_stall", stall_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("hold_frozen", {valid_o, MemRead_o, RTaddr_o, RSdata_o}, {1'b1, 1'b1, 5'd7, 32'h71});
      check_eq("hold_cnt", stall_cnt_o, 16'd1);
    end
    hold_i = 1'b0;
    step();
    check_eq("hold_rel_valid", valid_o, 1'b0);
    check_eq("hold_rel_cnt", stall_cnt_o, 16'd2);
    step();
    check_eq("hold_rel_add", {valid_o, RTaddr_o, RDaddr_o}, {1'b1, 5'd7, 5'd9});

    // 20 load-use stalls: 16-bit counter exact, 4-bit counter saturates
    for (int i = 0; i < 20; i++) begin
      set_id(5'd0, 5'd3, 5'd0, 32'h0, 32'h0, 32'h0, c_lw, 1'b1);
      step();
      set_id(5'd3, 5'd5, 5'd4, 32'h0, 32'h0, 32'h0, c_add, 1'b1);
      step();
      if (i == 12) check_eq("sat_cnt4_mid", stall_cnt4, 4'hF);
    end
    check_eq("sat_cnt16", stall_cnt_o, 16'd22);
    check_eq("sat_cnt4", stall_cnt4, 4'hF);

    // mid-stream load, then asynchronous reset mid-cycle
    set_id(5'd1, 5'd2, 5'd3, 32'hDEAD, 32'hBEEF, 32'h5, c_add, 1'b1);
    step();
    check_eq("pre_rst_valid", valid_o, 1'b1);
    #2;
    rst_i = 1'b0;
    #1;
    check_bubble("mid_rst");
    check_eq("mid_rst_cnt", stall_cnt_o, 16'd0);
    check_eq("mid_rst_cnt4", stall_cnt4, 4'd0);
    check_eq("mid_rst_stall", stall_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b1;
    set_id(5'd10, 5'd11, 5'd12, 32'hCAFE, 32'hF00D, 32'h7, c_add, 1'b1);
    step();
    check_eq("post_rst_load", {valid_o, RSdata_o, RDaddr_o}, {1'b1, 32'hCAFE, 5'd12});

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
